// File: rtl/game_pkg.sv
// Shared types for the guessing game: round FSM states, the 4-bit digit type
// used by the generator, scanner and display, and the score ceiling.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_KEY,
        JUDGE,
        SHOW
    } state_t;

    typedef logic [3:0] digit_t;

    localparam logic [7:0] SCORE_MAX = 8'd255;

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector: rise is high in the cycle where din is 1
// and was 0 at the previous clock edge.
module rise_detect (
    input  logic clk,
    input  logic res,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (res) begin
            prev <= 1'b0;
        end else begin
            prev <= din;
        end
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/guess_judge.sv
// Round controller for the guessing game: freezes a target, judges keypresses,
// counts attempts and score, and holds the registered result for display.
module guess_judge
    import game_pkg::*;
#(
    parameter int MAX_TRIES   = 3,
    parameter int SHOW_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       res,
    input  logic       start,
    input  logic [3:0] rand_num,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       rand_enable,
    output logic       motor_go,
    output logic       check,
    output logic       result_valid,
    output logic       miss,
    output logic [3:0] attempts,
    output logic [7:0] score
);

    localparam int              CNT_W      = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [3:0]       TRIES_LAST = 4'(MAX_TRIES);

    state_t           state, state_n;
    digit_t           target, target_n;
    digit_t           guess, guess_n;
    logic [3:0]       attempts_n;
    logic [7:0]       score_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             rand_enable_n, motor_go_n, check_n, result_valid_n, miss_n;
    logic             start_rise, key_rise;

    rise_detect u_start_rise (
        .clk  (clk),
        .res  (res),
        .din  (start),
        .rise (start_rise)
    );

    rise_detect u_key_rise (
        .clk  (clk),
        .res  (res),
        .din  (key_valid),
        .rise (key_rise)
    );

    // Every output is computed here and registered below, so the display and
    // motor stages only ever see clean flop outputs.
    always_comb begin
        state_n    = state;
        target_n   = target;
        guess_n    = guess;
        attempts_n = attempts;
        score_n    = score;
        cnt_n      = cnt;
        check_n    = check;
        motor_go_n = 1'b0;
        miss_n     = 1'b0;

        case (state)
            IDLE: begin
                check_n = 1'b0;
                cnt_n   = '0;
                if (start_rise) begin
                    target_n   = rand_num;
                    attempts_n = 4'd0;
                    motor_go_n = 1'b1;
                    state_n    = WAIT_KEY;
                end
            end
            WAIT_KEY: begin
                if (key_rise) begin
                    guess_n    = key_code;
                    attempts_n = attempts + 4'd1;
                    state_n    = JUDGE;
                end
            end
            JUDGE: begin
                if (guess == target) begin
                    check_n = 1'b1;
                    if (score != SCORE_MAX) begin
                        score_n = score + 8'd1;
                    end
                    cnt_n   = '0;
                    state_n = SHOW;
                end else if (attempts == TRIES_LAST) begin
                    check_n = 1'b0;
                    cnt_n   = '0;
                    state_n = SHOW;
                end else begin
                    miss_n  = 1'b1;
                    state_n = WAIT_KEY;
                end
            end
            SHOW: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    check_n = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        rand_enable_n  = (state_n == IDLE);
        result_valid_n = (state_n == SHOW);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state        <= IDLE;
            target       <= '0;
            guess        <= '0;
            attempts     <= 4'd0;
            score        <= 8'd0;
            cnt          <= '0;
            rand_enable  <= 1'b1;
            motor_go     <= 1'b0;
            check        <= 1'b0;
            result_valid <= 1'b0;
            miss         <= 1'b0;
        end else begin
            state        <= state_n;
            target       <= target_n;
            guess        <= guess_n;
            attempts     <= attempts_n;
            score        <= score_n;
            cnt          <= cnt_n;
            rand_enable  <= rand_enable_n;
            motor_go     <= motor_go_n;
            check        <= check_n;
            result_valid <= result_valid_n;
            miss         <= miss_n;
        end
    end

endmodule

// File: tb/tb_guess_judge.sv
// Randomized round-level bench for guess_judge, checked against a
// transaction-level model of the game rules (target, tries, score).
module tb_guess_judge;

    localparam int MAX_TRIES   = 3;
    localparam int SHOW_CYCLES = 4;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       start = 1'b0;
    logic [3:0] rand_num = 4'd0;
    logic [3:0] key_code = 4'd0;
    logic       key_valid = 1'b0;
    logic       rand_enable, motor_go, check, result_valid, miss;
    logic [3:0] attempts;
    logic [7:0] score;

    int vectors     = 0;
    int miscompares = 0;
    int model_score = 0;

    guess_judge #(
        .MAX_TRIES   (MAX_TRIES),
        .SHOW_CYCLES (SHOW_CYCLES)
    ) dut (
        .clk          (clk),
        .res          (res),
        .start        (start),
        .rand_num     (rand_num),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .rand_enable  (rand_enable),
        .motor_go     (motor_go),
        .check        (check),
        .result_valid (result_valid),
        .miss         (miss),
        .attempts     (attempts),
        .score        (score)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_rand_enable"}, rand_enable, 1);
        checkOutput({tag, "_motor_go"}, motor_go, 0);
        checkOutput({tag, "_check"}, check, 0);
        checkOutput({tag, "_result_valid"}, result_valid, 0);
        checkOutput({tag, "_miss"}, miss, 0);
        checkOutput({tag, "_attempts"}, attempts, 0);
        checkOutput({tag, "_score"}, score, 0);
    endtask

    // Start edge from IDLE: motor kicked for exactly one cycle, generator stopped.
    task automatic applyStimulus(input logic [3:0] t);
        start    = 1'b1;
        rand_num = t;
        step();
        checkOutput("motor_go_rise", motor_go, 1);
        checkOutput("rand_enable_off", rand_enable, 0);
        checkOutput("attempts_clear", attempts, 0);
        start    = 1'b0;
        rand_num = 4'($urandom);
        step();
        checkOutput("motor_go_fall", motor_go, 0);
    endtask

    // One keypress in WAIT_KEY; the outcome follows purely from the game rules.
    task automatic pressKey(input logic [3:0] g, input logic [3:0] t, input int try_no,
                            input bit poke_start, output bit done);
        bit hit;
        hit       = (g == t);
        done      = hit || (try_no == MAX_TRIES);
        key_code  = g;
        key_valid = 1'b1;
        step();
        checkOutput("judge_quiet", int'(miss | result_valid), 0);
        key_code = 4'($urandom);
        step();
        if (done) begin
            if (hit && model_score < 255) model_score++;
            checkOutput("result_valid_rise", result_valid, 1);
            checkOutput("check_value", check, int'(hit));
            checkOutput("attempts_final", attempts, try_no);
            checkOutput("score_value", score, model_score);
            checkOutput("no_miss_at_end", miss, 0);
            key_valid = 1'b0;
            for (int j = 1; j < SHOW_CYCLES; j++) begin
                if (poke_start && j == 1) begin
                    start    = 1'b1;
                    rand_num = 4'($urandom);
                end
                step();
                checkOutput("result_valid_hold", result_valid, 1);
                checkOutput("check_hold", check, int'(hit));
                checkOutput("show_no_motor", motor_go, 0);
            end
            step();
            checkOutput("result_valid_fall", result_valid, 0);
            checkOutput("back_idle", rand_enable, 1);
        end else begin
            checkOutput("miss_pulse", miss, 1);
            checkOutput("attempts_count", attempts, try_no);
            checkOutput("no_result_on_miss", result_valid, 0);
            key_valid = 1'b0;
            step();
            checkOutput("miss_one_cycle", miss, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          done;
        logic [3:0]  t, g;
        logic [3:0]  misses [3];

        // Reset then idle
        res = 1'b1;
        step();
        step();
        checkReset("reset");
        res = 1'b0;
        step();
        checkOutput("idle_rand_enable", rand_enable, 1);

        // Hit on the first guess
        applyStimulus(4'd9);
        pressKey(4'd9, 4'd9, 1, 1'b0, done);
        step();

        // Three misses
        misses[0] = 4'd1;
        misses[1] = 4'd2;
        misses[2] = 4'd3;
        applyStimulus(4'd5);
        for (int i = 0; i < MAX_TRIES; i++) begin
            pressKey(misses[i], 4'd5, i + 1, 1'b0, done);
        end
        checkOutput("three_miss_done", int'(done), 1);
        step();

        // Key held across the start edge must not be judged
        key_code  = 4'd7;
        key_valid = 1'b1;
        applyStimulus(4'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("held_key_ignored", int'(miss | result_valid), 0);
            checkOutput("held_key_attempts", attempts, 0);
        end
        key_valid = 1'b0;
        step();
        // start in WAIT_KEY is ignored and the target stays 7
        start    = 1'b1;
        rand_num = 4'd2;
        step();
        checkOutput("start_in_wait_ignored", motor_go, 0);
        start = 1'b0;
        step();
        pressKey(4'd7, 4'd7, 1, 1'b1, done);
        // start held through SHOW does not restart the next round
        step();
        checkOutput("held_start_no_motor", motor_go, 0);
        checkOutput("held_start_stays_idle", rand_enable, 1);
        start = 1'b0;
        step();

        // Reset while in JUDGE
        applyStimulus(4'd3);
        key_code  = 4'd3;
        key_valid = 1'b1;
        step();
        res = 1'b1;
        step();
        checkReset("reset_judge");
        model_score = 0;
        res       = 1'b0;
        key_valid = 1'b0;
        step();

        // Reset while in SHOW
        applyStimulus(4'd4);
        key_code  = 4'd4;
        key_valid = 1'b1;
        step();
        step();
        checkOutput("show_entered", result_valid, 1);
        res = 1'b1;
        step();
        checkReset("reset_show");
        model_score = 0;
        res       = 1'b0;
        key_valid = 1'b0;
        step();

        // Randomized rounds
        for (int r = 0; r < 30; r++) begin
            t = 4'($urandom);
            applyStimulus(t);
            for (int i = 1; i <= MAX_TRIES; i++) begin
                g = ($urandom_range(0, 2) == 0) ? t : 4'($urandom);
                pressKey(g, t, i, 1'b0, done);
                if (done) break;
            end
            repeat ($urandom_range(1, 3)) step();
        end

        // Score saturation
        for (int r = 0; r < 260; r++) begin
            t = 4'($urandom);
            applyStimulus(t);
            pressKey(t, t, 1, 1'b0, done);
        end
        checkOutput("score_saturated", score, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/guess_judge.md
# guess_judge

Round controller between the keypad scanner and the display/motor stages of the guessing game. It consumes the scanner's `key_code`/`key_valid` and the random generator's `rand_num`, then:
- freezes the target number at round start;
- judges each keypress against the target;
- counts attempts and keeps a running score;
- drives the registered `check`/result strobes the seven-segment stage displays.

It also gates the random generator and kicks the step motor once per round.

## Interface
Parameters:
- `MAX_TRIES`, 3: wrong guesses allowed per round (1..15).
- `SHOW_CYCLES`, 50_000_000: cycles the result is held before returning to idle (≥1).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `res`  in  1  reset; synchronous, active-high.
- `start`  in  1  debounced start button, level.
- `rand_num`  in  4  free-running random value from the generator.
- `key_code`  in  4  scanned key value; valid only while `key_valid`=1.
- `key_valid`  in  1  high while a key is held.
- `rand_enable`  out  1  generator run enable.
- `motor_go`  out  1  one-cycle motor start pulse.
- `check`  out  1  1 = round won; meaningful while `result_valid`=1.
- `result_valid`  out  1  high for exactly `SHOW_CYCLES` cycles per finished round.
- `miss`  out  1  one-cycle pulse on each wrong guess that does not end the round.
- `attempts`  out  4  guesses made in the current round.
- `score`  out  8  rounds won since reset; saturates at 255.

## Operation
States: IDLE, WAIT_KEY, JUDGE, SHOW.

- **IDLE**
  - `rand_enable`=1.
  - On a rising edge of `start` (1 now, 0 in the previous cycle): latch `rand_num` into `target`, clear `attempts`, pulse `motor_go`, go to WAIT_KEY.
- **WAIT_KEY**
  - `rand_enable`=0.
  - On a rising edge of `key_valid`: latch `key_code` into `guess`, increment `attempts`, go to JUDGE.
- **JUDGE** (one cycle)
  - If `guess`==`target`: `check`←1, `score`←min(`score`+1, 255), go to SHOW.
  - Else if `attempts`==`MAX_TRIES`: `check`←0, go to SHOW.
  - Else: pulse `miss`, return to WAIT_KEY.
- **SHOW**
  - `result_valid`=1; `check` and `attempts` held.
  - Cycle counter runs from 0 to `SHOW_CYCLES`−1; on the last count go to IDLE.
  - In IDLE: `check`←0, counter←0.

Edge detectors on `start` and `key_valid` sample every cycle in all states. Consequences:
- A key held while entering WAIT_KEY is ignored until it is released and pressed again.
- A `start` held through a round does not restart the next round.
- `start` outside IDLE is ignored.
- Key edges in IDLE, JUDGE or SHOW are ignored; they are not queued.

Reset (`res`=1 at a clock edge, any state, including mid-round or mid-SHOW):
- state←IDLE.
- `target`, `guess`, `attempts`, `score`, counter, edge-detector history ← 0.
- Outputs: `rand_enable`=1, `motor_go`=0, `check`=0, `result_valid`=0, `miss`=0, `attempts`=0, `score`=0.

Widths:
- `attempts` never exceeds `MAX_TRIES`; it is compared unsigned, 4-bit.
- The SHOW counter width is $clog2(`SHOW_CYCLES`), minimum 1.
- `score` saturates at 255; it never wraps.

## Timing
- All outputs are registered.
- `start` first sampled high at edge s:
  - `motor_go`=1 and `rand_enable`=0 after edge s.
  - `motor_go`=0 after edge s+1.
  - `target` is the `rand_num` sampled at edge s.
- `key_valid` first sampled high at edge k:
  - state JUDGE after edge k.
  - After edge k+1, one of: state SHOW with `result_valid`/`check`/`score` updated; or `miss`=1 for one cycle.
  - Judge latency is 2 cycles.
- A new key edge is accepted no earlier than edge k+2.
- `result_valid` rises after edge k+1 and falls after edge k+1+`SHOW_CYCLES`; it is high for exactly `SHOW_CYCLES` cycles.
- `start` already high at the end of SHOW does not begin a round; it must fall and rise again.

## Structure
- Package `game_pkg`:
  - `state_t` enum (IDLE, WAIT_KEY, JUDGE, SHOW);
  - `digit_t` (logic [3:0]) shared with the generator, scanner and display;
  - `SCORE_MAX` = 8'd255.
- Sub-module `rise_detect`: 1-bit synchronous rising-edge detector with synchronous reset. Instantiated twice, for `start` and `key_valid`.
- Top body: the FSM, target/guess registers, attempt and score counters, SHOW timer.

## Test plan
Bench parameters: `MAX_TRIES`=3, `SHOW_CYCLES`=4.

- **Reset then idle:** hold `res` 2 cycles.
  - Expect `rand_enable`=1 and every other output 0.
  - Pulse `start` with `rand_num`=9 → `motor_go` high exactly 1 cycle, `rand_enable`=0, target 9.
- **Hit:** target 9; press `key_code`=9 (`key_valid` rises at edge k).
  - Expect `check`=1, `result_valid`=1 from edge k+1 for 4 cycles, `score`=1, `attempts`=1, then IDLE.
- **Three misses:** target 5; press 1, 2, 3 with releases between.
  - Expect `miss` pulses after guesses 1 and 2, none after guess 3.
  - Expect `result_valid` for 4 cycles with `check`=0, `attempts`=3, `score` unchanged.
- **Held key and ignored start:**
  - Keep `key_valid` high across the `start` edge → no judgement until release and re-press.
  - Pulse `start` during WAIT_KEY and SHOW → no `motor_go` and `target` unchanged.
- **Reset mid-round:** assert `res` in JUDGE and again in SHOW.
  - Expect state IDLE, `score`=0, `result_valid`=0 on the next cycle.
- **Score saturation:** force 256 winning rounds → `score` stays 255.
